// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shift_pkg;

   localparam int WIDTH = 16;
   localparam int AMT_W = 4;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRA  = 2'b01,
      SH_ROR  = 2'b10,
      SH_RSVD = 2'b11
   } shift_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response channels for both requesters of the shift arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface shift_arbiter_if;
   import shift_pkg::*;

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_data;
   logic [AMT_W-1:0] req0_amt;
   logic [1:0]       req0_mode;
   logic             rsp0_valid;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp0_ready;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_data;
   logic [AMT_W-1:0] req1_amt;
   logic [1:0]       req1_mode;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp1_data;
   logic             rsp1_ready;

   modport master (
      output req0_valid, req0_data, req0_amt, req0_mode, rsp0_ready,
      output req1_valid, req1_data, req1_amt, req1_mode, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_data,
      input  req1_ready, rsp1_valid, rsp1_data
   );

   modport slave (
      input  req0_valid, req0_data, req0_amt, req0_mode, rsp0_ready,
      input  req1_valid, req1_data, req1_amt, req1_mode, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_data,
      output req1_ready, rsp1_valid, rsp1_data
   );

endinterface

// File: rtl/shift_arbiter_core.sv
// Combinational 16-bit log shifter: four stages of 1/2/4/8 bits.
// Rotation is built per stage by feeding the bits that fall off bit 0
// back in at the top, so no pair of opposing shifts is ever OR-ed.
module shift_core
   import shift_pkg::*;
(
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_amt,
   input  shift_mode_t      i_mode,
   output logic [WIDTH-1:0] o_result
);

   // One fixed-distance stage; s is a constant at every call site, so each
   // output bit reduces to a small mux over the mode.
   function automatic logic [WIDTH-1:0] shiftStage(
      input logic [WIDTH-1:0] x,
      input int               s,
      input shift_mode_t      m
   );
      logic [WIDTH-1:0] y;
      y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (m)
            SH_SLL:  y[i] = (i >= s) ? x[(i - s + WIDTH) % WIDTH] : 1'b0;
            SH_SRA:  y[i] = (i + s < WIDTH) ? x[(i + s) % WIDTH] : x[WIDTH-1];
            SH_ROR:  y[i] = x[(i + s) % WIDTH];
            default: y[i] = 1'b0;
         endcase
      end
      return y;
   endfunction

   logic [WIDTH-1:0] w_stage1;
   logic [WIDTH-1:0] w_stage2;
   logic [WIDTH-1:0] w_stage3;
   logic [WIDTH-1:0] w_stage4;

   assign w_stage1 = i_amt[0] ? shiftStage(i_data,   1, i_mode) : i_data;
   assign w_stage2 = i_amt[1] ? shiftStage(w_stage1, 2, i_mode) : w_stage1;
   assign w_stage3 = i_amt[2] ? shiftStage(w_stage2, 4, i_mode) : w_stage2;
   assign w_stage4 = i_amt[3] ? shiftStage(w_stage3, 8, i_mode) : w_stage3;

   // The reserved mode always yields zero, whatever the amount.
   assign o_result = (i_mode == SH_RSVD) ? '0 : w_stage4;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift core between the ALU issue path
// (requester 0) and the address/immediate path (requester 1). One operation
// is in flight: IDLE accepts, EXEC computes and registers, RESP returns.
// Datapath width and amount width come from shift_pkg (only 16/4 supported).
module shift_arbiter
   import shift_pkg::*;
#(
   parameter bit RR_FIRST = 1'b0
)
(
   input  logic            clk,
   input  logic            rst_n,
   shift_arbiter_if.slave  bus,
   output logic            busy,
   output logic            err_mode
);

   arb_state_t       r_state;
   arb_state_t       w_nextState;

   logic             r_lastGrant;
   logic             r_gntId;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_amt;
   shift_mode_t      r_mode;

   logic             r_rsp0Valid;
   logic [WIDTH-1:0] r_rsp0Data;
   logic             r_rsp1Valid;
   logic [WIDTH-1:0] r_rsp1Data;

   logic             w_ready0;
   logic             w_ready1;
   logic             w_accept;
   logic             w_acceptId;
   logic             w_rspDone;
   logic [WIDTH-1:0] w_result;

   shift_core u_core (
      .i_data   (r_data),
      .i_amt    (r_amt),
      .i_mode   (r_mode),
      .o_result (w_result)
   );

   // State register; reset drops any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Grant selection in IDLE, response handshake in RESP, next state.
   always_comb begin
      w_nextState = r_state;
      w_ready0    = 1'b0;
      w_ready1    = 1'b0;
      w_rspDone   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (rst_n) begin
               if (bus.req0_valid && bus.req1_valid) begin
                  w_ready0 = r_lastGrant;
                  w_ready1 = !r_lastGrant;
               end else begin
                  w_ready0 = bus.req0_valid;
                  w_ready1 = bus.req1_valid;
               end
               if (w_ready0 || w_ready1) begin
                  w_nextState = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            w_nextState = ST_RESP;
         end
         ST_RESP: begin
            w_rspDone = r_gntId ? bus.rsp1_ready : bus.rsp0_ready;
            if (w_rspDone) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign w_accept   = w_ready0 | w_ready1;
   assign w_acceptId = w_ready1;

   // Latch the winning operation and remember who won for round-robin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= ~RR_FIRST;
         r_gntId     <= 1'b0;
         r_data      <= '0;
         r_amt       <= '0;
         r_mode      <= SH_SLL;
      end else if (w_accept) begin
         r_lastGrant <= w_acceptId;
         r_gntId     <= w_acceptId;
         r_data      <= w_acceptId ? bus.req1_data : bus.req0_data;
         r_amt       <= w_acceptId ? bus.req1_amt  : bus.req0_amt;
         r_mode      <= shift_mode_t'(w_acceptId ? bus.req1_mode : bus.req0_mode);
      end
   end

   // Response registers: loaded for the granted port in EXEC, cleared on its handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp0Valid <= 1'b0;
         r_rsp0Data  <= '0;
         r_rsp1Valid <= 1'b0;
         r_rsp1Data  <= '0;
      end else if (r_state == ST_EXEC) begin
         if (r_gntId) begin
            r_rsp1Valid <= 1'b1;
            r_rsp1Data  <= w_result;
         end else begin
            r_rsp0Valid <= 1'b1;
            r_rsp0Data  <= w_result;
         end
      end else if (w_rspDone) begin
         if (r_gntId) begin
            r_rsp1Valid <= 1'b0;
            r_rsp1Data  <= '0;
         end else begin
            r_rsp0Valid <= 1'b0;
            r_rsp0Data  <= '0;
         end
      end
   end

   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;
   assign bus.rsp0_valid = r_rsp0Valid;
   assign bus.rsp0_data  = r_rsp0Data;
   assign bus.rsp1_valid = r_rsp1Valid;
   assign bus.rsp1_data  = r_rsp1Data;

   assign busy     = (r_state != ST_IDLE);
   assign err_mode = (r_state == ST_EXEC) && (r_mode == SH_RSVD);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a table of single operations with
// hand-computed results, then hand-written sequences for round-robin
// alternation, a stalled response and reset in the middle of RESP.
module tb_shift_arbiter;

   logic clk;
   logic rst_n;
   logic busy;
   logic err_mode;

   shift_arbiter_if bus ();

   shift_arbiter #(.RR_FIRST(1'b0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .err_mode (err_mode)
   );

   typedef struct {
      int          id;
      logic [1:0]  mode;
      logic [15:0] data;
      logic [3:0]  amt;
      logic [15:0] expRes;
      logic        expErr;
      string       name;
   } vec_t;

   vec_t vecs [12];
   int   nChecks = 0;
   int   nFails  = 0;

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the sequencing.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison funnels through here so counting is in one place.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_mode = '0;
      bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_mode = '0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      clearInputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic driveReq(input int id, input logic [1:0] mode, input logic [15:0] data, input logic [3:0] amt);
      if (id == 0) begin
         bus.req0_valid = 1'b1; bus.req0_mode = mode; bus.req0_data = data; bus.req0_amt = amt;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_mode = mode; bus.req1_data = data; bus.req1_amt = amt;
      end
   endtask

   // Wait (bounded) for the given requester to see ready; returns just before the accepting edge.
   task automatic waitGrant(input int id, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
      if (!ok) #1;
   endtask

   // Wait (bounded) for either ready and report which one.
   task automatic waitAny(output int id, output bit ok);
      ok = 1'b0;
      id = -1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
            ok = 1'b1;
            id = bus.req1_ready ? 1 : 0;
            checkOutput("single_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            break;
         end
         @(posedge clk);
      end
      if (!ok) #1;
   endtask

   // One complete operation with rsp_ready held high, checked at every stage.
   task automatic applyStimulus(input vec_t v);
      bit ok;
      logic gv, ov;
      logic [15:0] gd;
      driveReq(v.id, v.mode, v.data, v.amt);
      if (v.id == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      waitGrant(v.id, ok);
      checkOutput({v.name, "_grant"}, {31'd0, ok}, 32'd1);
      checkOutput({v.name, "_other_ready"},
                  {31'd0, (v.id == 0) ? bus.req1_ready : bus.req0_ready}, 32'd0);
      if (!ok) begin
         clearInputs();
         return;
      end
      tick();
      if (v.id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
      gv = (v.id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      checkOutput({v.name, "_exec_err"},   {31'd0, err_mode}, {31'd0, v.expErr});
      checkOutput({v.name, "_exec_busy"},  {31'd0, busy},     32'd1);
      checkOutput({v.name, "_exec_valid"}, {31'd0, gv},       32'd0);
      tick();
      gv = (v.id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      ov = (v.id == 0) ? bus.rsp1_valid : bus.rsp0_valid;
      gd = (v.id == 0) ? bus.rsp0_data  : bus.rsp1_data;
      checkOutput({v.name, "_resp_valid"}, {31'd0, gv},       32'd1);
      checkOutput({v.name, "_resp_data"},  {16'd0, gd},       {16'd0, v.expRes});
      checkOutput({v.name, "_resp_other"}, {31'd0, ov},       32'd0);
      checkOutput({v.name, "_resp_err"},   {31'd0, err_mode}, 32'd0);
      tick();
      gv = (v.id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      checkOutput({v.name, "_idle_valid"}, {31'd0, gv},   32'd0);
      checkOutput({v.name, "_idle_busy"},  {31'd0, busy}, 32'd0);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
   endtask

   initial begin
      bit ok;
      int gid;

      // Single-operation vectors: {id, mode, data, amt, result, err_mode in EXEC}.
      vecs[0]  = '{0, 2'b00, 16'h0001, 4'd4,  16'h0010, 1'b0, "sll_1_4"};
      vecs[1]  = '{1, 2'b01, 16'h8000, 4'd15, 16'hFFFF, 1'b0, "sra_8000_15"};
      vecs[2]  = '{1, 2'b10, 16'h1234, 4'd4,  16'h4123, 1'b0, "ror_1234_4"};
      vecs[3]  = '{0, 2'b10, 16'hBEEF, 4'd0,  16'hBEEF, 1'b0, "ror_beef_0"};
      vecs[4]  = '{0, 2'b11, 16'hFFFF, 4'd3,  16'h0000, 1'b1, "rsvd_ffff_3"};
      vecs[5]  = '{1, 2'b00, 16'h8001, 4'd1,  16'h0002, 1'b0, "sll_8001_1"};
      vecs[6]  = '{0, 2'b01, 16'h7F00, 4'd8,  16'h007F, 1'b0, "sra_7f00_8"};
      vecs[7]  = '{1, 2'b10, 16'h0001, 4'd15, 16'h0002, 1'b0, "ror_0001_15"};
      vecs[8]  = '{0, 2'b00, 16'hFFFF, 4'd15, 16'h8000, 1'b0, "sll_ffff_15"};
      vecs[9]  = '{1, 2'b01, 16'h1234, 4'd0,  16'h1234, 1'b0, "sra_1234_0"};
      vecs[10] = '{0, 2'b10, 16'h8421, 4'd9,  16'h10C2, 1'b0, "ror_8421_9"};
      vecs[11] = '{1, 2'b11, 16'h1234, 4'd7,  16'h0000, 1'b1, "rsvd_1234_7"};

      // Reset state, with a request pending to show ready stays low under reset.
      rst_n = 1'b0;
      clearInputs();
      bus.req0_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req0_ready",  {31'd0, bus.req0_ready}, 32'd0);
      checkOutput("rst_req1_ready",  {31'd0, bus.req1_ready}, 32'd0);
      checkOutput("rst_rsp0_valid",  {31'd0, bus.rsp0_valid}, 32'd0);
      checkOutput("rst_rsp1_valid",  {31'd0, bus.rsp1_valid}, 32'd0);
      checkOutput("rst_rsp0_data",   {16'd0, bus.rsp0_data},  32'd0);
      checkOutput("rst_rsp1_data",   {16'd0, bus.rsp1_data},  32'd0);
      checkOutput("rst_busy",        {31'd0, busy},           32'd0);
      checkOutput("rst_err_mode",    {31'd0, err_mode},       32'd0);
      bus.req0_valid = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
      end

      // Both requesters continuously valid after reset: grants go 0,1,0,1.
      doReset();
      driveReq(0, 2'b00, 16'h0003, 4'd1);
      driveReq(1, 2'b10, 16'h000F, 4'd4);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      for (int op = 0; op < 4; op++) begin
         waitAny(gid, ok);
         checkOutput($sformatf("rr_grant_ok_%0d", op), {31'd0, ok}, 32'd1);
         checkOutput($sformatf("rr_grant_id_%0d", op), gid, op % 2);
         tick();
         tick();
         if (op % 2 == 0) begin
            checkOutput($sformatf("rr_valid_%0d", op), {31'd0, bus.rsp0_valid}, 32'd1);
            checkOutput($sformatf("rr_data_%0d", op),  {16'd0, bus.rsp0_data},  32'h0006);
            checkOutput($sformatf("rr_other_%0d", op), {31'd0, bus.rsp1_valid}, 32'd0);
         end else begin
            checkOutput($sformatf("rr_valid_%0d", op), {31'd0, bus.rsp1_valid}, 32'd1);
            checkOutput($sformatf("rr_data_%0d", op),  {16'd0, bus.rsp1_data},  32'hF000);
            checkOutput($sformatf("rr_other_%0d", op), {31'd0, bus.rsp0_valid}, 32'd0);
         end
         tick();
      end
      clearInputs();
      tick();

      // Stalled response on requester 0 while requester 1 waits.
      driveReq(0, 2'b00, 16'h0001, 4'd4);
      waitGrant(0, ok);
      checkOutput("stall_grant", {31'd0, ok}, 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      driveReq(1, 2'b01, 16'h8000, 4'd15);
      tick();
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("stall_valid_%0d", k),  {31'd0, bus.rsp0_valid}, 32'd1);
         checkOutput($sformatf("stall_data_%0d", k),   {16'd0, bus.rsp0_data},  32'h0010);
         checkOutput($sformatf("stall_busy_%0d", k),   {31'd0, busy},           32'd1);
         checkOutput($sformatf("stall_ready0_%0d", k), {31'd0, bus.req0_ready}, 32'd0);
         checkOutput($sformatf("stall_ready1_%0d", k), {31'd0, bus.req1_ready}, 32'd0);
         tick();
      end
      bus.rsp0_ready = 1'b1;
      #1;
      checkOutput("stall_ready1_on_hs", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      bus.rsp0_ready = 1'b0;
      #1;
      checkOutput("stall_idle_busy",  {31'd0, busy},           32'd0);
      checkOutput("stall_idle_valid", {31'd0, bus.rsp0_valid}, 32'd0);
      checkOutput("stall_idle_data",  {16'd0, bus.rsp0_data},  32'd0);
      checkOutput("stall_next_grant", {31'd0, bus.req1_ready}, 32'd1);
      tick();
      bus.req1_valid = 1'b0;
      tick();

      // Reset while requester 1 sits in RESP: everything drops at once.
      checkOutput("mid_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
      checkOutput("mid_rsp1_data",  {16'd0, bus.rsp1_data},  32'hFFFF);
      bus.req0_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
      checkOutput("mid_rst_rsp1_data",  {16'd0, bus.rsp1_data},  32'd0);
      checkOutput("mid_rst_busy",       {31'd0, busy},           32'd0);
      checkOutput("mid_rst_ready0",     {31'd0, bus.req0_ready}, 32'd0);
      checkOutput("mid_rst_ready1",     {31'd0, bus.req1_ready}, 32'd0);
      clearInputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("post_rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
      checkOutput("post_rst_busy",       {31'd0, busy},           32'd0);
      applyStimulus(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
